// File: rtl/node_integrator_pkg.sv
// Shared constants for the node integrator: datapath width, voltage rails
// and the settle state encoding.
package node_integrator_pkg;

   localparam int W = 16;

   localparam logic signed [W-1:0] HI = 16'sd16384;
   localparam logic signed [W-1:0] LO = -16'sd16384;

   typedef logic [0:0] state_t;

   localparam state_t ST_SLEW    = 1'b0;
   localparam state_t ST_SETTLED = 1'b1;

endpackage

// File: rtl/current_summer.sv
// Combinational signed sum of N packed currents, widened so the total never
// overflows before it reaches the integrator.
module current_summer #(
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int SW = W + $clog2(N) + 1
) (
   input  logic [N*W-1:0]        i_in,
   output logic signed [SW-1:0]  sum
);

   logic signed [W-1:0] slice;

   // Sign-extend every slice to the full sum width before accumulating.
   always_comb begin
      sum   = '0;
      slice = '0;
      for (int k = 0; k < N; k++) begin
         slice = i_in[k*W +: W];
         sum   = sum + SW'(slice);
      end
   end

endmodule

// File: rtl/node_integrator.sv
// Node voltage integrator: accumulates scaled input current into a clamped
// voltage register, tracks a hysteretic logic level and detects settling.
module node_integrator
   import node_integrator_pkg::*;
#(
   parameter int N      = 4,
   parameter int CSHIFT = 2,
   parameter int EPS    = 1,
   parameter int SETTLE = 8,
   parameter logic signed [W-1:0] VTH_HI = HI >>> 1,
   parameter logic signed [W-1:0] VTH_LO = LO >>> 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                step,
   input  logic                load,
   input  logic signed [W-1:0] load_v,
   input  logic [N*W-1:0]      i_in,
   output logic signed [W-1:0] v,
   output logic                logic_out,
   output logic                settled,
   output logic                sat
);

   localparam int SW = W + $clog2(N) + 1;
   localparam int CW = $clog2(SETTLE + 1);

   localparam logic [CW-1:0]    SETTLE_C = CW'(SETTLE);
   localparam logic signed [SW:0] EPS_X  = (SW+1)'(EPS);
   localparam logic signed [SW:0] HI_X   = (SW+1)'(HI);
   localparam logic signed [SW:0] LO_X   = (SW+1)'(LO);

   // Saturate a full-width voltage onto the rails.
   function automatic logic signed [W-1:0] clamp_v(input logic signed [SW:0] x);
      if (x > HI_X)      return HI;
      else if (x < LO_X) return LO;
      else               return x[W-1:0];
   endfunction

   function automatic logic out_of_range(input logic signed [SW:0] x);
      return (x > HI_X) || (x < LO_X);
   endfunction

   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] dv;
   logic signed [SW:0]   v_full;
   logic signed [SW:0]   dv_abs;
   logic signed [W-1:0]  v_step;
   logic                 quiet;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_next;
   state_t               state;

   current_summer #(
      .N  (N),
      .W  (W),
      .SW (SW)
   ) u_summer (
      .i_in (i_in),
      .sum  (sum)
   );

   // Capacitance scaling: arithmetic shift floors toward minus infinity.
   assign dv = sum >>> CSHIFT;

   // Candidate step result and quiet decision; a step pinned at a rail that
   // leaves v unchanged is quiet even when the raw dv is large.
   always_comb begin
      v_full = (SW+1)'(v) + (SW+1)'(dv);
      v_step = clamp_v(v_full);
      dv_abs = dv[SW-1] ? -((SW+1)'(dv)) : (SW+1)'(dv);
      quiet  = (dv_abs <= EPS_X) || (v_step == v);
      if (!quiet)                cnt_next = '0;
      else if (cnt == SETTLE_C)  cnt_next = cnt;
      else                       cnt_next = cnt + CW'(1);
   end

   // Voltage, clamp flag, quiet counter and settle state; load beats step.
   always_ff @(posedge clk) begin
      if (reset) begin
         v     <= LO;
         sat   <= 1'b0;
         cnt   <= '0;
         state <= ST_SLEW;
      end else if (load) begin
         v     <= clamp_v((SW+1)'(load_v));
         sat   <= 1'b0;
         cnt   <= '0;
         state <= ST_SLEW;
      end else if (step) begin
         v     <= v_step;
         sat   <= out_of_range(v_full);
         cnt   <= cnt_next;
         if (!quiet)
            state <= ST_SLEW;
         else if (cnt_next == SETTLE_C)
            state <= ST_SETTLED;
      end
   end

   // Hysteretic logic level derived from the registered voltage.
   always_ff @(posedge clk) begin
      if (reset)
         logic_out <= 1'b0;
      else if (v > VTH_HI)
         logic_out <= 1'b1;
      else if (v < VTH_LO)
         logic_out <= 1'b0;
   end

   assign settled = (state == ST_SETTLED);

endmodule

// File: tb/tb_node_integrator.sv
// Directed bench for node_integrator with an integer reference model that is
// compared against the DUT on every cycle after the first reset.
module tb_node_integrator;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               step = 1'b0;
   logic               load = 1'b0;
   logic signed [15:0] load_v = '0;
   logic [63:0]        i_in = '0;
   logic signed [15:0] v;
   logic               logic_out;
   logic               settled;
   logic               sat;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // reference model state
   int mv = 0, msat = 0, mcnt = 0, mset = 0, mlog = 0;

   always #5 clk = ~clk;

   node_integrator dut (
      .clk       (clk),
      .reset     (reset),
      .step      (step),
      .load      (load),
      .load_v    (load_v),
      .i_in      (i_in),
      .v         (v),
      .logic_out (logic_out),
      .settled   (settled),
      .sat       (sat)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int clampi(input int x);
      if (x > 16384)  return 16384;
      if (x < -16384) return -16384;
      return x;
   endfunction

   // Reference model: plain integer arithmetic on the sampled inputs.
   always @(posedge clk) begin
      int s, r, d, raw, nv, ad;
      logic signed [15:0] sl;
      if (reset) begin
         mv = -16384; msat = 0; mcnt = 0; mset = 0; mlog = 0;
      end else begin
         if (mv > 8192)       mlog = 1;
         else if (mv < -8192) mlog = 0;
         if (load) begin
            mv = clampi(int'(load_v)); msat = 0; mcnt = 0; mset = 0;
         end else if (step) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
               sl = i_in[k*16 +: 16];
               s  = s + int'(sl);
            end
            r = s % 4;
            if (r < 0) r = r + 4;
            d   = (s - r) / 4;
            raw = mv + d;
            nv  = clampi(raw);
            msat = (nv != raw) ? 1 : 0;
            ad  = (d < 0) ? -d : d;
            if (ad <= 1 || nv == mv) begin
               if (mcnt < 8) mcnt = mcnt + 1;
               if (mcnt == 8) mset = 1;
            end else begin
               mcnt = 0; mset = 0;
            end
            mv = nv;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_v", int'(v), mv);
         chk("model_sat", int'(sat), msat);
         chk("model_settled", int'(settled), mset);
         chk("model_logic_out", int'(logic_out), mlog);
      end
   end

   task automatic tick(input bit r, input bit ld, input bit st, input int lv,
                       input int a, input int b, input int c, input int d);
      reset  = r;
      load   = ld;
      step   = st;
      load_v = 16'(lv);
      i_in   = {16'(d), 16'(c), 16'(b), 16'(a)};
      @(posedge clk);
      #1;
      reset = 1'b0;
      load  = 1'b0;
      step  = 1'b0;
   endtask

   task automatic steps(input int n, input int a, input int b, input int c, input int d);
      for (int i = 0; i < n; i++) tick(0, 0, 1, 0, a, b, c, d);
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset values
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      cmp_en = 1'b1;
      chk("rst_v", int'(v), -16384);
      chk("rst_logic_out", int'(logic_out), 0);
      chk("rst_settled", int'(settled), 0);
      chk("rst_sat", int'(sat), 0);

      // integration: dv = (100-20)>>>2 = 20
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      steps(1, 100, -20, 0, 0);
      chk("int_v1", int'(v), 20);
      steps(1, 100, -20, 0, 0);
      chk("int_v2", int'(v), 40);
      chk("int_sat", int'(sat), 0);
      idle();
      chk("hold_v", int'(v), 40);

      // floor rounding of negative sums: -5>>>2 = -2, -1>>>2 = -1
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      steps(1, -5, 0, 0, 0);
      chk("floor_m5", int'(v), -2);
      steps(1, -1, 0, 0, 0);
      chk("floor_m1", int'(v), -3);

      // load clamps to the rails without flagging sat
      tick(0, 1, 0, 30000, 0, 0, 0, 0);
      chk("load_clamp_hi", int'(v), 16384);
      chk("load_clamp_sat", int'(sat), 0);
      tick(0, 1, 0, -30000, 0, 0, 0, 0);
      chk("load_clamp_lo", int'(v), -16384);

      // saturation at HI, then pinned steps settle
      tick(0, 1, 0, 16000, 0, 0, 0, 0);
      steps(1, 4000, 4000, 0, 0);
      chk("sat_v", int'(v), 16384);
      chk("sat_flag", int'(sat), 1);
      chk("sat_settled0", int'(settled), 0);
      steps(7, 4000, 4000, 0, 0);
      chk("sat_settled7", int'(settled), 0);
      steps(1, 4000, 4000, 0, 0);
      chk("sat_settled8", int'(settled), 1);
      chk("sat_v_pinned", int'(v), 16384);

      // settle and break
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      steps(8, 4, 4, 4, 4);
      chk("loud_settled", int'(settled), 0);
      chk("loud_v", int'(v), 32);
      steps(7, 4, 0, 0, 0);
      chk("quiet7_settled", int'(settled), 0);
      steps(1, 4, 0, 0, 0);
      chk("quiet8_settled", int'(settled), 1);
      chk("quiet8_v", int'(v), 40);
      steps(1, 20, 0, 0, 0);
      chk("break_settled", int'(settled), 0);
      chk("break_v", int'(v), 45);
      steps(7, 4, 0, 0, 0);
      chk("rearm7_settled", int'(settled), 0);
      steps(1, 4, 0, 0, 0);
      chk("rearm8_settled", int'(settled), 1);

      // hysteresis thresholds are strict
      tick(0, 1, 0, -16384, 0, 0, 0, 0);
      idle();
      chk("hys_low", int'(logic_out), 0);
      tick(0, 1, 0, 8192, 0, 0, 0, 0);
      idle();
      chk("hys_at_vth_hi", int'(logic_out), 0);
      tick(0, 1, 0, 8193, 0, 0, 0, 0);
      idle();
      chk("hys_above_vth_hi", int'(logic_out), 1);
      tick(0, 1, 0, -8192, 0, 0, 0, 0);
      idle();
      chk("hys_at_vth_lo", int'(logic_out), 1);
      tick(0, 1, 0, -8193, 0, 0, 0, 0);
      idle();
      chk("hys_below_vth_lo", int'(logic_out), 0);

      // ramp up in 1000 steps from -16384
      tick(0, 1, 0, -16384, 0, 0, 0, 0);
      steps(24, 4000, 0, 0, 0);
      chk("ramp_up_v24", int'(v), 7616);
      steps(1, 4000, 0, 0, 0);
      chk("ramp_up_v25", int'(v), 8616);
      chk("ramp_up_latency", int'(logic_out), 0);
      idle();
      chk("ramp_up_rise", int'(logic_out), 1);
      // ramp down
      steps(16, -4000, 0, 0, 0);
      chk("ramp_dn_v", int'(v), -7384);
      idle();
      chk("ramp_dn_hold", int'(logic_out), 1);
      steps(1, -4000, 0, 0, 0);
      chk("ramp_dn_latency", int'(logic_out), 1);
      idle();
      chk("ramp_dn_fall", int'(logic_out), 0);

      // priority: load beats step
      tick(0, 1, 1, 1234, 4000, 4000, 4000, 4000);
      chk("prio_load_v", int'(v), 1234);
      chk("prio_load_sat", int'(sat), 0);

      // priority: reset beats load and step mid-slew
      tick(0, 1, 0, 16000, 0, 0, 0, 0);
      steps(1, 4000, 4000, 0, 0);
      idle();
      chk("prio_pre_sat", int'(sat), 1);
      chk("prio_pre_logic", int'(logic_out), 1);
      tick(1, 1, 1, 100, 4000, 0, 0, 0);
      chk("prio_rst_v", int'(v), -16384);
      chk("prio_rst_sat", int'(sat), 0);
      chk("prio_rst_settled", int'(settled), 0);
      chk("prio_rst_logic", int'(logic_out), 0);
      idle();

      @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
